breakout_motion_ctrl: RTL



---
 rtl/breakout_motion_if.sv | 23 ++
 rtl/breakout_motion_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/breakout_motion_if.sv
// breakout_motion_if: frame_tick/buttons/launch in, paddle/ball positions, lives, mode flags and sequencer status out
interface breakout_motion_if;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       launch;
  logic [9:0] paddle_x;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [1:0] lives;
  logic       playing;
  logic       game_over;
  logic       busy;
  logic       frame_done;
  modport master (
    output frame_tick, btn_left, btn_right, launch,
    input  paddle_x, ball_x, ball_y, lives, playing, game_over, busy, frame_done
  );
  modport slave (
    input  frame_tick, btn_left, btn_right, launch,
    output paddle_x, ball_x, ball_y, lives, playing, game_over, busy, frame_done
  );
endinterface

// File: rtl/breakout_motion_ctrl.sv
// breakout_motion_ctrl: per-frame Breakout paddle/ball sequencer; clk, rst, bus (slave: tick/buttons/launch in, positions/lives/status out)
module breakout_motion_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_W    = 160,
  parameter int PADDLE_Y    = 400,
  parameter int BALL_SIZE   = 5,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_STEP   = 2,
  parameter int LIVES_INIT  = 3
) (
  input logic clk,
  input logic rst,
  breakout_motion_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PADDLE, BALL, RESOLVE, COMMIT} state_t;
  typedef enum logic [1:0] {SERVE, PLAY, OVER} mode_t;
  localparam logic [10:0] PMAX  = 11'(SCREEN_W - PADDLE_W);
  localparam logic [10:0] PSTEP = 11'(PADDLE_STEP);
  localparam logic [10:0] BSTEP = 11'(BALL_STEP);
  localparam logic [10:0] BSZ   = 11'(BALL_SIZE);
  localparam logic [10:0] PY    = 11'(PADDLE_Y);
  localparam logic [10:0] PW    = 11'(PADDLE_W);
  localparam logic [10:0] SW    = 11'(SCREEN_W);
  localparam logic [10:0] SH    = 11'(SCREEN_H);
  localparam logic [10:0] OFS   = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [10:0] SY    = 11'(PADDLE_Y - BALL_SIZE);
  localparam logic [10:0] PX0   = 11'((SCREEN_W - PADDLE_W) / 2);
  localparam logic [1:0]  LIV0  = 2'(LIVES_INIT);
  state_t state_q, state_d;
  mode_t mode_q, mode_d, nmode_q, nmode_d;
  logic [1:0] lives_q, lives_d, nlives_q, nlives_d;
  logic dx_q, dx_d, dy_q, dy_d, done_q, done_d;
  logic [10:0] wpx_q, wpx_d, wbx_q, wbx_d, wby_q, wby_d;
  logic [9:0] px_q, px_d, bx_q, bx_d, by_q, by_d;
  logic [10:0] px, x, y;
  logic hit, miss, unused;
  assign px = {1'b0, px_q};
  assign x = {1'b0, bx_q};
  assign y = {1'b0, by_q};
  // x/y are the pre-move position, wby_q the moved row, wpx_q this frame's paddle
  assign hit = dy_q && (y + BSZ <= PY) && (wby_q + BSZ > PY) && (x + BSZ > wpx_q) && (x < wpx_q + PW);
  // a moving-up ball wraps wby_q near 2047, so the 11-bit sum stays small and never flags a miss
  assign miss = !hit && (wby_q + BSZ >= SH);
  assign unused = wbx_q[10];
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    nmode_d = nmode_q;
    lives_d = lives_q;
    nlives_d = nlives_q;
    dx_d = dx_q;
    dy_d = dy_q;
    done_d = 1'b0;
    wpx_d = wpx_q;
    wbx_d = wbx_q;
    wby_d = wby_q;
    px_d = px_q;
    bx_d = bx_q;
    by_d = by_q;
    case (state_q)
      IDLE: state_d = (bus.frame_tick && mode_q != OVER) ? PADDLE : IDLE;
      PADDLE: begin
        state_d = BALL;
        nmode_d = mode_q;
        nlives_d = lives_q;
        wpx_d = (bus.btn_left && !bus.btn_right) ? ((px < PSTEP) ? 11'd0 : px - PSTEP)
              : (bus.btn_right && !bus.btn_left) ? ((px + PSTEP > PMAX) ? PMAX : px + PSTEP) : px;
      end
      BALL: begin
        state_d = RESOLVE;
        wbx_d = (mode_q == SERVE) ? wpx_q + OFS : (dx_q ? x + BSTEP : x - BSTEP);
        wby_d = (mode_q == SERVE) ? SY : (dy_q ? y + BSTEP : y - BSTEP);
        if (mode_q == SERVE && bus.launch) begin
          nmode_d = PLAY;
          dx_d = 1'b1;
          dy_d = 1'b0;
        end
      end
      RESOLVE: begin
        state_d = COMMIT;
        if (mode_q == PLAY) begin
          if (!dx_q && x < BSTEP) begin
            wbx_d = 11'd0;
            dx_d = 1'b1;
          end
          if (dx_q && x + BSZ + BSTEP > SW) begin
            wbx_d = SW - BSZ;
            dx_d = 1'b0;
          end
          if (!dy_q && y < BSTEP) begin
            wby_d = 11'd0;
            dy_d = 1'b1;
          end
          if (hit) begin
            wby_d = SY;
            dy_d = 1'b0;
          end
          if (miss) begin
            nlives_d = lives_q - 2'd1;
            nmode_d = (lives_q == 2'd1) ? OVER : SERVE;
            wbx_d = (lives_q == 2'd1) ? x : wpx_q + OFS;
            wby_d = (lives_q == 2'd1) ? y : SY;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        px_d = wpx_q[9:0];
        bx_d = wbx_q[9:0];
        by_d = wby_q[9:0];
        mode_d = nmode_q;
        lives_d = nlives_q;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= SERVE;
      nmode_q <= SERVE;
      lives_q <= LIV0;
      nlives_q <= LIV0;
      dx_q <= 1'b1;
      dy_q <= 1'b0;
      done_q <= 1'b0;
      wpx_q <= PX0;
      wbx_q <= PX0 + OFS;
      wby_q <= SY;
      px_q <= PX0[9:0];
      bx_q <= 10'(PX0 + OFS);
      by_q <= SY[9:0];
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      nmode_q <= nmode_d;
      lives_q <= lives_d;
      nlives_q <= nlives_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      done_q <= done_d;
      wpx_q <= wpx_d;
      wbx_q <= wbx_d;
      wby_q <= wby_d;
      px_q <= px_d;
      bx_q <= bx_d;
      by_q <= by_d;
    end
  end
  assign bus.paddle_x = px_q;
  assign bus.ball_x = bx_q;
  assign bus.ball_y = by_q;
  assign bus.lives = lives_q;
  assign bus.playing = mode_q == PLAY;
  assign bus.game_over = mode_q == OVER;
  assign bus.busy = state_q != IDLE;
  assign bus.frame_done = done_q;
endmodule
